reg_write_arbiter: RTL and testbench

Write-port arbiter and sequencer for the CPU's bank of 8-bit registers. Up to four requesters (decode/writeback, ALU result, load unit, debug port) each request a register write. The block picks one winner per cycle and drives the one-hot register-select lines, the shared write enable and the shared write data for the register bank. Writes go through one registered stage, so the bank sees clean, glitch-free select and enable signals.

---
 rtl/reg_write_arbiter.sv | 113 +++++++++++
 tb/tb_reg_write_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Write-port arbiter for the 8-bit register bank: one winner per cycle, registered grant/select/enable/data.
// Define REG_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed highest priority.
module reg_write_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter int AW     = 3,
  parameter int NREG   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*AW-1:0]       addr,
  input  logic [NREQ*DATA_W-1:0]   data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREG-1:0]          chosen,
  output logic                     w_en,
  output logic [DATA_W-1:0]        w_data,
  output logic                     err
);

  logic [NREQ-1:0]   elig;
  logic              found;
  logic [1:0]        win;
  logic [AW-1:0]     win_addr;
  logic [DATA_W-1:0] win_data;
  logic              in_range;
  logic [NREQ-1:0]   gnt_nxt;
  logic [NREG-1:0]   chosen_nxt;

`ifdef REG_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr;
  logic [1:0] idx;
`endif

  // Winner selection; a requester whose grant is showing is excluded so a held request is not granted twice
  always_comb begin
    elig  = req & ~gnt;
    found = 1'b0;
    win   = 2'd0;
`ifdef REG_ARB_ROUND_ROBIN_EN
    idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end else begin
        found = found;
      end
    end
`else
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[k]) begin
        found = 1'b1;
        win   = 2'(k);
      end else begin
        found = found;
      end
    end
`endif
  end

  // Route the winner's address and data, and decode the one-hot register select
  always_comb begin
    win_addr = {AW{1'b0}};
    win_data = {DATA_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (win == 2'(i)) begin
        win_addr = addr[i*AW +: AW];
        win_data = data[i*DATA_W +: DATA_W];
      end else begin
        win_addr = win_addr;
      end
    end
    in_range = int'(win_addr) < NREG;
    if (found) begin
      gnt_nxt = {{(NREQ-1){1'b0}}, 1'b1} << win;
    end else begin
      gnt_nxt = {NREQ{1'b0}};
    end
    for (int j = 0; j < NREG; j++) begin
      chosen_nxt[j] = found && in_range && (win_addr == AW'(j));
    end
  end

  // Output register stage; an out-of-range address still takes the grant but the write is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= {NREQ{1'b0}};
      chosen <= {NREG{1'b0}};
      w_en   <= 1'b0;
      w_data <= {DATA_W{1'b0}};
      err    <= 1'b0;
`ifdef REG_ARB_ROUND_ROBIN_EN
      ptr    <= 2'd0;
`endif
    end else begin
      gnt    <= gnt_nxt;
      chosen <= chosen_nxt;
      w_en   <= found && in_range;
      err    <= found && !in_range;
      if (found) begin
        w_data <= win_data;
`ifdef REG_ARB_ROUND_ROBIN_EN
        ptr    <= win + 2'd1;
`endif
      end else begin
        w_data <= w_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed literal cases plus randomized traffic against a behavioural model.
module tb_reg_write_arbiter;
  localparam int NREQ   = 4;
  localparam int DATA_W = 8;
  localparam int AW     = 3;
  localparam int NREG   = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*AW-1:0]     addr;
  logic [NREQ*DATA_W-1:0] data;
  logic [NREQ-1:0]        gnt;
  logic [NREG-1:0]        chosen;
  logic                   w_en;
  logic [DATA_W-1:0]      w_data;
  logic                   err;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  reg_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .AW(AW), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .data(data),
    .gnt(gnt), .chosen(chosen), .w_en(w_en), .w_data(w_data), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [NREQ-1:0]   m_gnt;
  logic [NREG-1:0]   m_chosen;
  logic              m_w_en;
  logic [DATA_W-1:0] m_w_data;
  logic              m_err;
  int                m_ptr;

  always @(posedge clk) begin
    int w;
    int a;
    w = -1;
    if (rst) begin
      m_gnt <= '0; m_chosen <= '0; m_w_en <= 1'b0; m_w_data <= '0; m_err <= 1'b0; m_ptr <= 0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
`ifdef REG_ARB_ROUND_ROBIN_EN
        int i;
        i = (m_ptr + k) % NREQ;
`else
        int i;
        i = k;
`endif
        if (w < 0 && req[i] && !m_gnt[i]) w = i;
      end
      if (w < 0) begin
        m_gnt <= '0; m_chosen <= '0; m_w_en <= 1'b0; m_err <= 1'b0;
      end else begin
        a = int'(addr[w*AW +: AW]);
        m_gnt    <= NREQ'(1 << w);
        m_w_data <= data[w*DATA_W +: DATA_W];
        m_ptr    <= (w + 1) % NREQ;
        if (a < NREG) begin
          m_chosen <= NREG'(1 << a); m_w_en <= 1'b1; m_err <= 1'b0;
        end else begin
          m_chosen <= '0; m_w_en <= 1'b0; m_err <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model plus structural invariants
  always @(negedge clk) begin
    if (check_en) begin
      check("gnt",    32'(gnt),    32'(m_gnt));
      check("chosen", 32'(chosen), 32'(m_chosen));
      check("w_en",   32'(w_en),   32'(m_w_en));
      check("w_data", 32'(w_data), 32'(m_w_data));
      check("err",    32'(err),    32'(m_err));
      check("gnt_onehot0",    32'($onehot0(gnt)),    32'd1);
      check("chosen_onehot0", 32'($onehot0(chosen)), 32'd1);
      check("w_en_vs_chosen", 32'(w_en),             32'(|chosen));
    end
  end

  task automatic set_req(input int i, input int a, input int d);
    addr[i*AW +: AW]         = AW'(a);
    data[i*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [NREG-1:0] c,
                            input logic we, input logic [7:0] wd, input logic e);
    check({tag, "_gnt"},    32'(gnt),    32'(g));
    check({tag, "_chosen"}, 32'(chosen), 32'(c));
    check({tag, "_w_en"},   32'(w_en),   32'(we));
    check({tag, "_w_data"}, 32'(w_data), 32'(wd));
    check({tag, "_err"},    32'(err),    32'(e));
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; addr = '0; data = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 8'h10 + i);
    @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    expect_out("reset", 4'b0000, 6'b000000, 1'b0, 8'h00, 1'b0);

    // First grant after reset release goes to requester 0
    rst = 1'b0;
    @(negedge clk);
    expect_out("post_reset", 4'b0001, 6'b000001, 1'b1, 8'h10, 1'b0);
    @(negedge clk);
    check("post_reset_2nd_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'h0);

    // Single write to register 5
    set_req(2, 5, 8'hA7); req = 4'b0100;
    @(negedge clk);
    expect_out("single", 4'b0100, 6'b100000, 1'b1, 8'hA7, 1'b0);
    req = 4'b0000;
    @(negedge clk);
    expect_out("single_idle", 4'b0000, 6'b000000, 1'b0, 8'hA7, 1'b0);

    // Two held requests alternate
    set_req(0, 1, 8'h31); set_req(1, 2, 8'h42); req = 4'b0011;
    @(negedge clk); check("alt_0", 32'(gnt), 32'h1);
    @(negedge clk); check("alt_1", 32'(gnt), 32'h2);
    @(negedge clk); check("alt_2", 32'(gnt), 32'h1);
    @(negedge clk); expect_out("alt_3", 4'b0010, 6'b000100, 1'b1, 8'h42, 1'b0);
    req = 4'b0000;
    @(negedge clk);

    // Out-of-range address: grant issued, write dropped
    set_req(1, 7, 8'h5C); req = 4'b0010;
    @(negedge clk);
    expect_out("addr_err", 4'b0010, 6'b000000, 1'b0, 8'h5C, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    check("addr_err_pulse", 32'(err), 32'h0);

    // Reset while a grant is showing
    set_req(0, 3, 8'h99); req = 4'b0001;
    @(negedge clk);
    expect_out("pre_rst", 4'b0001, 6'b001000, 1'b1, 8'h99, 1'b0);
    rst = 1'b1; req = 4'b1111;
    @(negedge clk);
    expect_out("mid_rst", 4'b0000, 6'b000000, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("resume_gnt", 32'(gnt), 32'h1);

    // Randomized traffic honouring the requester contract
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(req[i] && !gnt[i])) begin
          req[i] = ($urandom_range(0, 2) != 0);
          set_req(i, $urandom_range(0, 7), $urandom_range(0, 255));
        end
      end
      @(negedge clk);
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
